scratch_dwnld_router: RTL
=========================

Name: scratch_dwnld_router

Overview:
Parametrised successor to the single-PROM download splitter in the Scratch game top level. It takes the byte stream from the ioctl download port and routes each byte to one of PROM_N on-chip PROM regions or to SDRAM. SDRAM writes use a prog_we/sdram_ack handshake and a 1-deep skid buffer. It also produces busy/done status, a byte count and an additive checksum for the load.

Parameters:
SDRAM_AW, 22, SDRAM word-address width of prog_addr
PROM_START, 25'h0, first ioctl byte address of the PROM window
PROM_AW, 9, byte-address width of each PROM region (region size 2^PROM_AW)
PROM_N, 2, number of consecutive PROM regions (1..4)
SWAB, 0, 1 = swap byte lanes: even byte goes to the high lane

Ports:
clk  in  1  system clock, 48 MHz
rst_n  in  1  asynchronous active-low reset
downloading  in  1  high for the whole ROM load
ioctl_addr  in  25  byte address
ioctl_data  in  8  byte data
ioctl_wr  in  1  one-cycle byte strobe
prog_addr  out  SDRAM_AW  SDRAM word address
prog_data  out  8  byte to write; controller replicates it on both lanes
prog_mask  out  2  active-low lane mask
prog_we  out  1  SDRAM write request, held until ack
sdram_ack  in  1  SDRAM accepted the current request
prom_we  out  PROM_N  one-hot PROM write strobe
prom_addr  out  PROM_AW  PROM byte address
prom_data  out  8  PROM byte
dwnld_busy  out  1  downloading OR SDRAM request pending OR skid buffer full
dwnld_done  out  1  one-cycle pulse when the load completes
overflow  out  1  sticky: a byte was dropped
byte_cnt  out  25  bytes accepted since downloading rose
checksum  out  8  mod-256 sum of accepted bytes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; skid buffer empty.
- Decode:
  - PROM_BYTES = PROM_N<<PROM_AW.
  - A = ioctl_addr.
  - A < PROM_START: SDRAM, byte offset O = A.
  - PROM_START <= A < PROM_START+PROM_BYTES: PROM. Region r = (A-PROM_START)>>PROM_AW; prom_addr = low PROM_AW bits.
  - A above the PROM window: SDRAM, O = A-PROM_BYTES.
  - prog_addr = O[SDRAM_AW:1].
  - prog_mask: 2'b10 when O[0]^SWAB = 0 (low lane written), else 2'b01.
- PROM path, latency 1:
  - The cycle after ioctl_wr, prom_we[r] is high for exactly one cycle, with prom_addr and prom_data valid in that cycle.
  - Never stalls, independent of SDRAM state.
- SDRAM FSM, states IDLE and WAIT_ACK:
  - IDLE with an SDRAM byte (from the skid buffer first, else from ioctl_wr): load prog_* registers, raise prog_we next cycle, go to WAIT_ACK.
  - WAIT_ACK: prog_addr, prog_data and prog_mask stay stable.
  - sdram_ack in WAIT_ACK: prog_we drops next cycle. If the skid buffer is full, its entry is issued back to back (prog_we stays high, new fields); otherwise go to IDLE.
  - sdram_ack in IDLE is ignored.
- Skid buffer:
  - An SDRAM byte arriving during WAIT_ACK is stored if the buffer is empty.
  - If the buffer is full and no ack arrives that cycle, the byte is dropped, overflow is set, and the byte is not counted.
  - If the buffer is full and an ack arrives in the same cycle, the buffered entry issues and the new byte takes the buffer (no drop).
- Counters:
  - byte_cnt and checksum clear on the rising edge of downloading.
  - They update on every accepted byte (PROM or SDRAM) one cycle after ioctl_wr.
  - byte_cnt wraps at 2^25.
  - overflow clears only on rst_n or the rising edge of downloading.
- Done:
  - After downloading falls, dwnld_done pulses one cycle in the first cycle with FSM IDLE and the buffer empty.
  - If already flushed, it pulses the cycle after the fall.
- ioctl_wr while downloading=0 is ignored.
- rst_n low mid-transfer: immediate abort. The pending request is lost, prog_we=0, and no done pulse is generated.

Decomposition:
- Package scratch_dwnld_pkg: FSM state enum (IDLE, WAIT_ACK), decode result type (target SDRAM/PROM, region, offset), PROM_BYTES calculation function.
- One sub-module, scratch_dwnld_decode: combinational address decode only. It is instantiated once for ioctl input and reused for the skid entry. The FSM, skid buffer and counters stay in the top module.

Test Plan:
- PROM_START=0, write A=25'h005 D=8'hA5 -> next cycle prom_we=2'b01, prom_addr=9'h005, prom_data=8'hA5 for one cycle; byte_cnt=1, checksum=8'hA5.
- Write A=25'h203 D=8'h3C -> prom_we=2'b10, prom_addr=9'h003.
- Write A=25'h400 then 25'h401 with no ack -> first byte: prog_addr=0, mask=2'b10. Second byte buffered. Ack -> back-to-back second request with mask=2'b01; prog_we held high across the switch.
- Three SDRAM bytes on consecutive cycles, ack held low -> overflow=1, byte_cnt=2. Same stimulus with ack coincident with the third byte -> overflow=0, byte_cnt=3.
- SWAB=1, A=25'h400 -> mask=2'b01.
- downloading falls with a request pending -> dwnld_busy stays 1; ack -> dwnld_done pulses once. rst_n low mid-WAIT_ACK -> prog_we=0 asynchronously and no done pulse.

Source files
------------

// File: rtl/scratch_dwnld_pkg.sv
// Shared types and helpers for the Scratch download router.
// Holds the SDRAM FSM states, the decoded byte destination and the PROM window size.
package scratch_dwnld_pkg;

  typedef enum logic {IDLE, WAIT_ACK} state_e;

  typedef enum logic {TGT_SDRAM, TGT_PROM} target_e;

  typedef struct packed {
    target_e     target;
    logic [1:0]  region;
    logic [24:0] offset;
  } decode_t;

  function automatic logic [25:0] prom_bytes(input int n, input int aw);
    return 26'(n) << aw;
  endfunction

endpackage

// File: rtl/scratch_dwnld_decode.sv
// Combinational ioctl address decode: picks PROM region or SDRAM and computes the offset.
// SDRAM offsets above the PROM window are closed up so SDRAM sees a gap-free image.
module scratch_dwnld_decode
  import scratch_dwnld_pkg::*;
#(
  parameter logic [24:0] PROM_START = 25'h0,
  parameter int          PROM_AW    = 9,
  parameter int          PROM_N     = 2
) (
  input  logic [24:0] addr,
  output decode_t     dec
);

  localparam logic [25:0] PROM_BYTES = prom_bytes(PROM_N, PROM_AW);

  // The extra top bit acts as a borrow flag: set when addr lies below the window.
  logic [26:0] diff;
  assign diff = {2'b00, addr} - {2'b00, PROM_START};

  always_comb begin
    // NOTE: default every field first so no path through the if-chain infers a latch.
    dec = '0;
    if (diff[26]) begin
      dec.target = TGT_SDRAM;
      dec.offset = addr;
    end else if (diff[25:0] < PROM_BYTES) begin
      dec.target = TGT_PROM;
      dec.region = 2'(diff[25:0] >> PROM_AW);
      dec.offset = diff[24:0];
    end else begin
      dec.target = TGT_SDRAM;
      dec.offset = 25'({1'b0, addr} - PROM_BYTES);
    end
  end

endmodule

// File: rtl/scratch_dwnld_router.sv
// Routes ioctl download bytes to PROM_N on-chip PROM regions or to SDRAM via a
// prog_we/sdram_ack handshake with a 1-deep skid buffer, plus load status/count/checksum.
module scratch_dwnld_router
  import scratch_dwnld_pkg::*;
#(
  parameter int          SDRAM_AW   = 22,
  parameter logic [24:0] PROM_START = 25'h0,
  parameter int          PROM_AW    = 9,
  parameter int          PROM_N     = 2,
  parameter bit          SWAB       = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [SDRAM_AW-1:0] prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                sdram_ack,
  output logic [PROM_N-1:0]   prom_we,
  output logic [PROM_AW-1:0]  prom_addr,
  output logic [7:0]          prom_data,
  output logic                dwnld_busy,
  output logic                dwnld_done,
  output logic                overflow,
  output logic [24:0]         byte_cnt,
  output logic [7:0]          checksum
);

  decode_t dec;

  scratch_dwnld_decode #(
    .PROM_START (PROM_START),
    .PROM_AW    (PROM_AW),
    .PROM_N     (PROM_N)
  ) u_decode (
    .addr (ioctl_addr),
    .dec  (dec)
  );

  state_e              state;
  logic                dl_q;
  logic                done_pend;
  logic                sk_full;
  logic [SDRAM_AW-1:0] sk_addr;
  logic [1:0]          sk_mask;
  logic [7:0]          sk_data;

  logic                wr_ok, is_prom, is_sd;
  logic                issue_ok, dropped, accepted, sk_load;
  logic                dl_rise, dl_fall;
  logic [SDRAM_AW-1:0] new_addr;
  logic [1:0]          new_mask;
  logic                unused_offset;

  assign wr_ok    = ioctl_wr && downloading;
  assign is_prom  = wr_ok && (dec.target == TGT_PROM);
  assign is_sd    = wr_ok && (dec.target == TGT_SDRAM);
  assign new_addr = dec.offset[SDRAM_AW:1];
  assign new_mask = (dec.offset[0] ^ SWAB) ? 2'b01 : 2'b10;
  assign unused_offset = ^dec.offset;

  // A new request may be launched when idle or when the current one is acked this cycle.
  assign issue_ok = (state == IDLE) || sdram_ack;
  assign dropped  = is_sd && !issue_ok && sk_full;
  assign accepted = wr_ok && !dropped;
  // Skid is written when it frees up on issue and refills, or when it is empty and must hold.
  assign sk_load  = is_sd && (issue_ok ? sk_full : !sk_full);

  assign dl_rise  = downloading && !dl_q;
  assign dl_fall  = !downloading && dl_q;

  assign dwnld_busy = downloading || prog_we || sk_full;
  assign dwnld_done = done_pend && (state == IDLE) && !sk_full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      sk_full   <= 1'b0;
    end else if (issue_ok) begin
      if (sk_full) begin
        prog_addr <= sk_addr;
        prog_data <= sk_data;
        prog_mask <= sk_mask;
        prog_we   <= 1'b1;
        state     <= WAIT_ACK;
        sk_full   <= is_sd;
      end else if (is_sd) begin
        prog_addr <= new_addr;
        prog_data <= ioctl_data;
        prog_mask <= new_mask;
        prog_we   <= 1'b1;
        state     <= WAIT_ACK;
      end else begin
        prog_we   <= 1'b0;
        state     <= IDLE;
      end
    end else if (is_sd && !sk_full) begin
      sk_full <= 1'b1;
    end
  end

  // NOTE: skid payload is qualified by sk_full, so it needs no reset and carries none.
  always_ff @(posedge clk) begin
    if (sk_load) begin
      sk_addr <= new_addr;
      sk_mask <= new_mask;
      sk_data <= ioctl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prom_we   <= '0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= is_prom ? (PROM_N'(1) << dec.region) : '0;
      if (is_prom) begin
        prom_addr <= dec.offset[PROM_AW-1:0];
        prom_data <= ioctl_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q      <= 1'b0;
      done_pend <= 1'b0;
      byte_cnt  <= '0;
      checksum  <= '0;
      overflow  <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (dl_rise) begin
        byte_cnt  <= 25'(accepted);
        checksum  <= accepted ? ioctl_data : 8'h00;
        overflow  <= dropped;
        done_pend <= 1'b0;
      end else begin
        if (accepted) begin
          byte_cnt <= byte_cnt + 25'd1;
          checksum <= checksum + ioctl_data;
        end
        if (dropped)
          overflow <= 1'b1;
        if (dwnld_done)
          done_pend <= 1'b0;
        if (dl_fall)
          done_pend <= 1'b1;
      end
    end
  end

endmodule
